// File: rtl/crosswalk_request_if.sv
// Request/response link between the pedestrian-side initiator and the
// traffic-light controller.
//   button : initiator -> controller, level request held until served
//   lights : controller -> initiator, current 3-bit light code
interface crosswalk_request_if;
    logic       button;
    logic [2:0] lights;

    modport master (output button, input lights);
    modport slave  (input button, output lights);
endinterface

// File: rtl/crosswalk_request.sv
// Pedestrian-side request initiator: synchronises and debounces a raw
// push-button, holds a request towards the light controller until the GREEN
// code is seen, then locks out further presses through a cooldown.
// Ports:
//   clk          system clock, posedge
//   reset        synchronous active-high reset
//   btn_raw      asynchronous, bouncy pedestrian button
//   ctl          master side of the controller link (button out, lights in)
//   pending      high while a request is outstanding
//   busy         high while presses are ignored (served / cooldown)
//   served_count number of requests served, wraps 15->0
module crosswalk_request #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8,
    parameter logic [2:0]  GREEN_CODE      = 3'b111,
    parameter logic [2:0]  RED_CODE        = 3'b000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn_raw,
    crosswalk_request_if.master        ctl,
    output logic                       pending,
    output logic                       busy,
    output logic [3:0]                 served_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        REQUEST,
        SERVED,
        COOLDOWN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, btn_s_q;
    logic             serve_c;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            s1_q    <= btn_raw;
            btn_s_q <= s1_q;
        end
    end

    // State, shared counter, served counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            served_count <= 4'd0;
            ctl.button   <= 1'b0;
            pending      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (serve_c) begin
                served_count <= served_count + 4'd1;
            end
            // Outputs track the next state so they equal a decode of state_q
            ctl.button <= (state_d == REQUEST);
            pending    <= (state_d == REQUEST);
            busy       <= (state_d == SERVED) || (state_d == COOLDOWN);
        end
    end

    // Next-state logic; cnt counts debounce samples or cooldown cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        serve_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    cnt_d   = CNT_W'(1);
                    // A single-sample debounce accepts the press immediately
                    state_d = (DEBOUNCE_CYCLES == 1) ? REQUEST : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = REQUEST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQUEST: begin
                if (ctl.lights == GREEN_CODE) begin
                    state_d = SERVED;
                    serve_c = 1'b1;
                end
            end
            SERVED: begin
                if (ctl.lights == RED_CODE) begin
                    state_d = COOLDOWN;
                    cnt_d   = '0;
                end
            end
            COOLDOWN: begin
                // Counter saturates; a still-held button keeps the lockout
                if (cnt_q == CD_LAST) begin
                    if (!btn_s_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_crosswalk_request.sv
// Bench for crosswalk_request: a table of per-cycle {inputs, expected outputs}
// covering reset, a clean press, serve, cooldown with a held button and a
// fresh press; then hand sequences for bounce rejection, counter wrap, reset
// during a request and a request entering with the light already green.
module tb_crosswalk_request;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       pending;
    logic       busy;
    logic [3:0] served_count;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_cnt;

    crosswalk_request_if ctl_if ();

    crosswalk_request dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .ctl          (ctl_if),
        .pending      (pending),
        .busy         (busy),
        .served_count (served_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [2:0] lights;
        logic       exp_button;
        logic       exp_busy;
        logic [3:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic b, input logic [2:0] l,
                                input logic eb, input logic ebusy, input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.btn = b; v.lights = l;
        v.exp_button = eb; v.exp_busy = ebusy; v.exp_count = ec;
        vecs.push_back(v);
    endfunction

    // Apply inputs, take one rising edge, settle away from the edge
    task automatic step(input logic r, input logic b, input logic [2:0] l);
        reset         = r;
        btn_raw       = b;
        ctl_if.lights = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic eb, input logic ebusy,
                             input logic [3:0] ec);
        checks++;
        if (ctl_if.button !== eb) begin
            errors++;
            $display("FAIL %s button got=%b exp=%b", tag, ctl_if.button, eb);
        end
        checks++;
        if (pending !== eb) begin
            errors++;
            $display("FAIL %s pending got=%b exp=%b", tag, pending, eb);
        end
        checks++;
        if (busy !== ebusy) begin
            errors++;
            $display("FAIL %s busy got=%b exp=%b", tag, busy, ebusy);
        end
        checks++;
        if (served_count !== ec) begin
            errors++;
            $display("FAIL %s served_count got=%0d exp=%0d", tag, served_count, ec);
        end
    endtask

    // From IDLE with btn_s low: button rises after the 6th held sample
    task automatic press_to_request(input string tag, input logic [2:0] l);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, l);
            check_out($sformatf("%s_deb%0d", tag, k), 1'b0, 1'b0, exp_cnt);
        end
        step(1'b0, 1'b1, l);
        check_out($sformatf("%s_req", tag), 1'b1, 1'b0, exp_cnt);
    endtask

    // Bounded wait for cooldown to finish with the button released
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            step(1'b0, 1'b0, 3'b000);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_timeout busy got=%b exp=0", tag, busy);
        end
    endtask

    // GREEN for one cycle, then RED and wait out the cooldown
    task automatic serve(input string tag);
        step(1'b0, 1'b0, 3'b111);
        exp_cnt = exp_cnt + 4'd1;
        check_out($sformatf("%s_served", tag), 1'b0, 1'b1, exp_cnt);
        step(1'b0, 1'b0, 3'b000);
        check_out($sformatf("%s_cool", tag), 1'b0, 1'b1, exp_cnt);
        wait_idle(tag);
    endtask

    initial begin
        logic bounce [6];

        reset         = 1'b1;
        btn_raw       = 1'b0;
        ctl_if.lights = 3'b000;

        // Reset, then idle
        for (int k = 0; k < 2; k++)  add(1, 0, 3'b000, 0, 0, 4'd0);
        for (int k = 0; k < 20; k++) add(0, 0, 3'b000, 0, 0, 4'd0);
        // Clean press: edges 1..5 debouncing, edge 6 request, held to 9
        for (int k = 0; k < 5; k++)  add(0, 1, 3'b000, 0, 0, 4'd0);
        for (int k = 0; k < 4; k++)  add(0, 1, 3'b000, 1, 0, 4'd0);
        // Edge 10: GREEN served
        add(0, 1, 3'b111, 0, 1, 4'd1);
        // Other code keeps SERVED
        for (int k = 0; k < 5; k++)  add(0, 1, 3'b010, 0, 1, 4'd1);
        // RED sampled, then cooldown and held-button lockout
        for (int k = 0; k < 12; k++) add(0, 1, 3'b000, 0, 1, 4'd1);
        // Release: two synchroniser edges still see it held, then IDLE
        for (int k = 0; k < 2; k++)  add(0, 0, 3'b000, 0, 1, 4'd1);
        add(0, 0, 3'b000, 0, 0, 4'd1);
        // Fresh press yields a new request, served on the next GREEN
        for (int k = 0; k < 5; k++)  add(0, 1, 3'b000, 0, 0, 4'd1);
        add(0, 1, 3'b000, 1, 0, 4'd1);
        add(0, 0, 3'b111, 0, 1, 4'd2);
        for (int k = 0; k < 8; k++)  add(0, 0, 3'b000, 0, 1, 4'd2);
        add(0, 0, 3'b000, 0, 0, 4'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].btn, vecs[i].lights);
            check_out($sformatf("vec%0d", i), vecs[i].exp_button,
                      vecs[i].exp_busy, vecs[i].exp_count);
        end
        exp_cnt = 4'd2;

        // Bounce rejection: never reaches REQUEST
        bounce[0] = 1'b1; bounce[1] = 1'b1; bounce[2] = 1'b0;
        bounce[3] = 1'b1; bounce[4] = 1'b1; bounce[5] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, bounce[k], 3'b000);
            check_out($sformatf("bounce%0d", k), 1'b0, 1'b0, exp_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 3'b000);
            check_out($sformatf("bounce_tail%0d", k), 1'b0, 1'b0, exp_cnt);
        end
        press_to_request("after_bounce", 3'b000);
        serve("after_bounce");

        // Counter wrap from reset
        step(1'b1, 1'b0, 3'b000);
        exp_cnt = 4'd0;
        check_out("wrap_reset", 1'b0, 1'b0, exp_cnt);
        for (int s = 0; s < 16; s++) begin
            press_to_request($sformatf("wrap%0d", s), 3'b000);
            serve($sformatf("wrap%0d", s));
        end
        checks++;
        if (served_count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_final served_count got=%0d exp=0", served_count);
        end

        // Reset during REQUEST abandons it; full debounce needed again
        press_to_request("midreq", 3'b000);
        step(1'b1, 1'b1, 3'b000);
        check_out("midreq_reset", 1'b0, 1'b0, 4'd0);
        press_to_request("midreq_again", 3'b000);
        serve("midreq_again");

        // Already green on entry: button high for exactly one cycle
        press_to_request("green_entry", 3'b111);
        serve("green_entry");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
